vga_box_anim: RTL and testbench

- Pixel-generation stage directly downstream of the VGA sync generator.
- Consumes the sync generator's pixel_x, pixel_y, hsync and vsync, and produces the 8-bit RGB drive for the DAC/pins.
- Draws a solid square that bounces around the 640x480 visible area, moving once per frame.
- Delays hsync/vsync so they stay aligned with the registered RGB.

---
 rtl/vga_box_anim.sv | 157 +++++++++++++++
 tb/tb_vga_box_anim.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/vga_box_anim.sv
// Pixel stage after the VGA sync generator: draws a square that bounces once per frame.
// Define VGA_BOX_BORDER_EN to add a 4-pixel white frame and keep the box inside it.
module vga_box_anim #(
    parameter int         BOX_SIZE = 32,
    parameter int         SPEED    = 2,
    parameter logic [7:0] BOX_RGB  = 8'hE0,
    parameter logic [7:0] BG_RGB   = 8'h03
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       pause,
    output logic [7:0] rgb,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_tick
);

    localparam logic [10:0] H_VIS = 11'd640;
    localparam logic [10:0] V_VIS = 11'd480;
`ifdef VGA_BOX_BORDER_EN
    localparam logic [10:0] EDGE  = 11'd4;
`else
    localparam logic [10:0] EDGE  = 11'd0;
`endif
    localparam logic [10:0] X_LO  = EDGE;
    localparam logic [10:0] X_HI  = H_VIS - EDGE;
    localparam logic [10:0] Y_LO  = EDGE;
    localparam logic [10:0] Y_HI  = V_VIS - EDGE;
    localparam logic [10:0] SZ    = 11'(BOX_SIZE);
    localparam logic [10:0] SP    = 11'(SPEED);

    logic [9:0] box_x, box_y;
    logic       dir_x, dir_y;          // 1 = increasing coordinate
    logic [9:0] nxt_x, nxt_y;
    logic       nxt_dir_x, nxt_dir_y;
    logic       vs_d;
    logic       frame_tick_next;
    logic [1:0] hs_d, vsd;

    logic       video_on_s1, in_box_s1;
    logic [10:0] x11, y11, bx11, by11;

    assign x11  = {1'b0, pixel_x};
    assign y11  = {1'b0, pixel_y};
    assign bx11 = {1'b0, box_x};
    assign by11 = {1'b0, box_y};

    assign frame_tick_next = vs_d & ~vsync_in;

    // Bounce arithmetic is done 11 bits wide so the limit compares never wrap.
    always_comb begin
        nxt_x     = box_x;
        nxt_y     = box_y;
        nxt_dir_x = dir_x;
        nxt_dir_y = dir_y;
        if (dir_x) begin
            if (bx11 + SZ + SP >= X_HI) begin
                nxt_x     = 10'(X_HI - SZ);
                nxt_dir_x = 1'b0;
            end else begin
                nxt_x = 10'(bx11 + SP);
            end
        end else begin
            if (bx11 <= X_LO + SP) begin
                nxt_x     = 10'(X_LO);
                nxt_dir_x = 1'b1;
            end else begin
                nxt_x = 10'(bx11 - SP);
            end
        end
        if (dir_y) begin
            if (by11 + SZ + SP >= Y_HI) begin
                nxt_y     = 10'(Y_HI - SZ);
                nxt_dir_y = 1'b0;
            end else begin
                nxt_y = 10'(by11 + SP);
            end
        end else begin
            if (by11 <= Y_LO + SP) begin
                nxt_y     = 10'(Y_LO);
                nxt_dir_y = 1'b1;
            end else begin
                nxt_y = 10'(by11 - SP);
            end
        end
    end

    // Motion only on the vsync falling edge, i.e. during retrace.
    always_ff @(posedge clk) begin
        if (reset) begin
            box_x      <= 10'(X_LO);
            box_y      <= 10'(Y_LO);
            dir_x      <= 1'b1;
            dir_y      <= 1'b1;
            vs_d       <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            vs_d       <= vsync_in;
            frame_tick <= frame_tick_next;
            if (frame_tick_next && !pause) begin
                box_x <= nxt_x;
                box_y <= nxt_y;
                dir_x <= nxt_dir_x;
                dir_y <= nxt_dir_y;
            end
        end
    end

`ifdef VGA_BOX_BORDER_EN
    logic [9:0] x_s1, y_s1;
    logic       border_s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            x_s1 <= '0;
            y_s1 <= '0;
        end else begin
            x_s1 <= pixel_x;
            y_s1 <= pixel_y;
        end
    end

    assign border_s2 = (x_s1 < 10'd4) || (x_s1 > 10'd635) ||
                       (y_s1 < 10'd4) || (y_s1 > 10'd475);
`else
    logic border_s2;
    assign border_s2 = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            video_on_s1 <= 1'b0;
            in_box_s1   <= 1'b0;
            rgb         <= 8'h00;
            hs_d        <= 2'b11;
            vsd         <= 2'b11;
        end else begin
            video_on_s1 <= (x11 < H_VIS) && (y11 < V_VIS);
            in_box_s1   <= (x11 >= bx11) && (x11 < bx11 + SZ) &&
                           (y11 >= by11) && (y11 < by11 + SZ);
            if (!video_on_s1)   rgb <= 8'h00;
            else if (border_s2) rgb <= 8'hFF;
            else if (in_box_s1) rgb <= BOX_RGB;
            else                rgb <= BG_RGB;
            hs_d <= {hs_d[0], hsync_in};
            vsd  <= {vsd[0], vsync_in};
        end
    end

    assign hsync = hs_d[1];
    assign vsync = vsd[1];

endmodule

// File: tb/tb_vga_box_anim.sv
// Directed bench for vga_box_anim: pipeline latency, sync delay, frame tick, bounce and pause.
// Define VGA_BOX_BORDER_EN to exercise the border build instead of the default build.
module tb_vga_box_anim;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] pixel_x, pixel_y;
    logic       hsync_in, vsync_in, pause;
    logic [7:0] rgb;
    logic       hsync, vsync, frame_tick;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vga_box_anim dut (
        .clk       (clk),
        .reset     (reset),
        .pixel_x   (pixel_x),
        .pixel_y   (pixel_y),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .pause     (pause),
        .rgb       (rgb),
        .hsync     (hsync),
        .vsync     (vsync),
        .frame_tick(frame_tick)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive a pixel coordinate, then read rgb two clocks later.
    task automatic probe(input int x, input int y, input logic [7:0] exp, input string tag);
        @(negedge clk);
        pixel_x = 10'(x);
        pixel_y = 10'(y);
        repeat (2) @(negedge clk);
        check(tag, {8'h00, rgb}, {8'h00, exp});
    endtask

    // One vsync low pulse; returns how many frame_tick pulses were seen.
    task automatic do_frame(output int pulses);
        pulses = 0;
        @(negedge clk);
        vsync_in = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (frame_tick) pulses++;
        end
        vsync_in = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (frame_tick) pulses++;
        end
    endtask

    initial begin
        int p, total, first_low, low_cnt;
        reset    = 1'b1;
        pixel_x  = '0;
        pixel_y  = '0;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        pause    = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_rgb", {8'h00, rgb}, 16'h0000);
        check("rst_hsync", {15'h0, hsync}, 16'h1);
        check("rst_vsync", {15'h0, vsync}, 16'h1);
        check("rst_tick", {15'h0, frame_tick}, 16'h0);
        reset = 1'b0;
        @(negedge clk);
        check("rel_1clk", {8'h00, rgb}, 16'h0000);
        @(negedge clk);
`ifdef VGA_BOX_BORDER_EN
        check("rel_2clk", {8'h00, rgb}, 16'h00FF);
        probe(2, 2, 8'hFF, "brd_2_2");
        probe(4, 4, 8'hE0, "box_4_4");
        probe(3, 4, 8'hFF, "brd_3_4");
        probe(700, 100, 8'h00, "blank_700");
        for (int f = 0; f < 400; f++) begin
            do_frame(p);
            probe(3, 240, 8'hFF, "brd_left");
            probe(636, 240, 8'hFF, "brd_right");
            probe(320, 3, 8'hFF, "brd_top");
            probe(320, 476, 8'hFF, "brd_bot");
        end
`else
        check("rel_2clk", {8'h00, rgb}, 16'h00E0);
        probe(700, 100, 8'h00, "blank_x700");
        probe(100, 480, 8'h00, "blank_y480");
        probe(100, 100, 8'h03, "bg_100");
        probe(31, 31, 8'hE0, "box_31");
        probe(32, 0, 8'h03, "bg_32_0");

        // hsync low for 96 clocks must come out 2 clocks later, same width.
        first_low = -1;
        low_cnt   = 0;
        for (int i = 0; i < 110; i++) begin
            @(negedge clk);
            if (!hsync) begin
                low_cnt++;
                if (first_low < 0) first_low = i;
            end
            hsync_in = (i < 96) ? 1'b0 : 1'b1;
        end
        check("hs_delay", 16'(first_low), 16'd2);
        check("hs_width", 16'(low_cnt), 16'd96);
        check("vs_idle", {15'h0, vsync}, 16'h1);

        do_frame(p);
        check("tick_once", 16'(p), 16'd1);
        probe(33, 33, 8'hE0, "f1_box_33");
        probe(1, 1, 8'h03, "f1_bg_1");
        probe(2, 2, 8'hE0, "f1_box_2");
        probe(34, 34, 8'h03, "f1_bg_34");

        pause = 1'b1;
        total = 0;
        for (int f = 0; f < 5; f++) begin
            do_frame(p);
            total += p;
        end
        check("pause_ticks", 16'(total), 16'd5);
        probe(2, 2, 8'hE0, "pause_box_2");
        probe(1, 1, 8'h03, "pause_bg_1");
        pause = 1'b0;
        do_frame(p);
        probe(3, 3, 8'h03, "resume_bg_3");
        probe(4, 4, 8'hE0, "resume_box_4");

        // 301 more moves: 303 in total puts x at 606; y bounced at 448 and is back to 290.
        for (int f = 0; f < 301; f++) do_frame(p);
        probe(605, 290, 8'h03, "m303_bg_605");
        probe(606, 290, 8'hE0, "m303_box_606");
        probe(637, 290, 8'hE0, "m303_box_637");
        probe(638, 290, 8'h03, "m303_bg_638");
        probe(606, 289, 8'h03, "m303_bg_y289");
        probe(606, 321, 8'hE0, "m303_box_y321");
        probe(606, 322, 8'h03, "m303_bg_y322");

        do_frame(p);
        probe(607, 288, 8'h03, "m304_bg_607");
        probe(608, 288, 8'hE0, "m304_box_608");
        probe(639, 288, 8'hE0, "m304_box_639");
        probe(640, 288, 8'h00, "m304_blank_640");

        do_frame(p);
        probe(605, 286, 8'h03, "m305_bg_605");
        probe(606, 286, 8'hE0, "m305_box_606");
        probe(638, 286, 8'h03, "m305_bg_638");

        // Reset mid-frame returns the box to the origin.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        probe(0, 0, 8'hE0, "rerst_box_0");
        probe(32, 32, 8'h03, "rerst_bg_32");
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
